// File: rtl/vertex_transform_pkg.sv
// vertex_transform_pkg: Q1.10.10 constants, packed-matrix indexing and FSM states
package vertex_transform_pkg;
  localparam int Q_W = 21;
  localparam int Q_FRAC = 10;
  localparam int ACC_W = 46;
  localparam int MAT_W = 16 * Q_W;
  localparam logic [Q_W-1:0] Q_ONE = 21'h000400;
  localparam logic [Q_W-1:0] Q_MAX = 21'h0FFFFF;
  localparam logic [Q_W-1:0] Q_MIN = 21'h100000;
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  function automatic logic [8:0] elem_lsb(input logic [1:0] r, input logic [1:0] c);
    return 9'(MAT_W - Q_W * (4 * int'(c) + int'(r) + 1));
  endfunction
endpackage

// File: rtl/vertex_transform_q_mac.sv
// q_mac: signed MAC with floor or round-half-up (VTX_ROUND_EN) shift and 21-bit saturation
module q_mac
  import vertex_transform_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           first,
  input  logic [Q_W-1:0] a,
  input  logic [Q_W-1:0] b,
  output logic [Q_W-1:0] res,
  output logic           sat
);
  logic signed [2*Q_W-1:0] prod;
  logic signed [ACC_W-1:0] acc, sum, rnd, sh;
  logic hi, lo;
  assign prod = $signed(a) * $signed(b);
  assign sum = (first ? '0 : acc) + {{(ACC_W-2*Q_W){prod[2*Q_W-1]}}, prod};
`ifdef VTX_ROUND_EN
  assign rnd = sum + (ACC_W'(1) << (Q_FRAC - 1));
`else
  assign rnd = sum;
`endif
  assign sh = rnd >>> Q_FRAC;
  assign hi = !sh[ACC_W-1] && |sh[ACC_W-2:Q_W-1];
  assign lo = sh[ACC_W-1] && !(&sh[ACC_W-2:Q_W-1]);
  assign res = hi ? Q_MAX : lo ? Q_MIN : sh[Q_W-1:0];
  assign sat = hi || lo;
  // running sum of the current element's terms
  always_ff @(posedge clk or negedge rst)
    if (!rst) acc <= '0;
    else if (en) acc <= sum;
endmodule

// File: rtl/vertex_transform.sv
// vertex_transform: M = T x V over one time-multiplexed MAC; rounding via VTX_ROUND_EN
module vertex_transform
  import vertex_transform_pkg::*;
(
  input  logic             CLK,
  input  logic             rst,
  input  logic             start,
  input  logic [MAT_W-1:0] mtrx_T_in,
  input  logic [MAT_W-1:0] mtrx_V_in,
  input  logic [3:0]       state_in,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [MAT_W-1:0] mtrxOut,
  output logic [3:0]       matrixState
);
  state_t state, nxt;
  logic [MAT_W-1:0] t, v, wbuf;
  logic [3:0] tag;
  logic [1:0] r, c, k;
  logic [Q_W-1:0] a, b, res;
  logic wovf, sat, go, mac_en, commit, last;
  assign a = t[elem_lsb(r, k) +: Q_W];
  assign b = v[elem_lsb(k, c) +: Q_W];
  assign last = &{r, c, k};
  q_mac u_mac (
    .clk(CLK), .rst(rst), .en(mac_en), .first(k == 2'd0),
    .a(a), .b(b), .res(res), .sat(sat)
  );
  // state register
  always_ff @(posedge CLK or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  // next-state logic
  always_comb
    nxt = state == IDLE ? (start ? MAC : IDLE) : state == MAC ? (last ? DONE : MAC) : IDLE;
  // FSM decodes
  always_comb begin
    busy = state == MAC;
    mac_en = state == MAC;
    go = state == IDLE && start;
    commit = state == DONE;
  end
  // operand capture, term/element indices and working result buffer
  always_ff @(posedge CLK or negedge rst)
    if (!rst) begin
      t <= '0;
      v <= '0;
      tag <= '0;
      wbuf <= '0;
      wovf <= 1'b0;
      {r, c, k} <= '0;
    end else if (go) begin
      t <= mtrx_T_in;
      v <= mtrx_V_in;
      tag <= state_in;
      wovf <= 1'b0;
      {r, c, k} <= '0;
    end else if (mac_en) begin
      k <= k + 2'd1;
      if (k == 2'd3) begin
        wbuf[elem_lsb(r, c) +: Q_W] <= res;
        wovf <= wovf | sat;
        r <= r + 2'd1;
        c <= r == 2'd3 ? c + 2'd1 : c;
      end
    end
  // atomic publication of the finished product
  always_ff @(posedge CLK or negedge rst)
    if (!rst) begin
      done <= 1'b0;
      ovf <= 1'b0;
      mtrxOut <= '0;
      matrixState <= '0;
    end else begin
      done <= commit;
      if (commit) begin
        mtrxOut <= wbuf;
        matrixState <= tag;
        ovf <= wovf;
      end
    end
endmodule

// File: tb/tb_vertex_transform.sv
// tb_vertex_transform: randomized products checked against an integer matrix-multiply model
module tb_vertex_transform;
  logic CLK, rst, start, busy, done, ovf;
  logic [335:0] mtrx_T_in, mtrx_V_in, mtrxOut;
  logic [3:0] state_in, matrixState;
  int checks = 0;
  int failures = 0;

  vertex_transform dut (
    .CLK(CLK), .rst(rst), .start(start), .mtrx_T_in(mtrx_T_in), .mtrx_V_in(mtrx_V_in),
    .state_in(state_in), .busy(busy), .done(done), .ovf(ovf), .mtrxOut(mtrxOut),
    .matrixState(matrixState)
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [335:0] got, input logic [335:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] ge(input logic [335:0] m, input int r, input int c);
    return m[335-21*(4*c+r) -: 21];
  endfunction

  function automatic longint el(input logic [335:0] m, input int r, input int c);
    logic signed [20:0] e;
    e = ge(m, r, c);
    return longint'(e);
  endfunction

  function automatic logic [335:0] put(input logic [335:0] m, input int r, input int c, input logic [20:0] x);
    m[335-21*(4*c+r) -: 21] = x;
    return m;
  endfunction

  function automatic logic [335:0] diag(input logic [20:0] d);
    logic [335:0] m = '0;
    for (int i = 0; i < 4; i++) m = put(m, i, i, d);
    return m;
  endfunction

  function automatic logic [335:0] rmat(input bit big);
    logic [335:0] m;
    for (int i = 0; i < 16; i++)
      m = put(m, i % 4, i / 4, big ? 21'($urandom) : 21'($urandom_range(0, 8191)) - 21'd4096);
    return m;
  endfunction

  function automatic void model(input logic [335:0] tm, input logic [335:0] vm,
                                output logic [335:0] m, output logic o);
    longint s;
    m = '0;
    o = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        s = 0;
        for (int k = 0; k < 4; k++) s += el(tm, r, k) * el(vm, k, c);
`ifdef VTX_ROUND_EN
        s += 512;
`endif
        s = s >>> 10;
        if (s > 1048575) begin s = 1048575; o = 1; end
        else if (s < -1048576) begin s = -1048576; o = 1; end
        m = put(m, r, c, 21'(s));
      end
  endfunction

  task automatic run(input logic [335:0] tm, input logic [335:0] vm, input logic [3:0] tg,
                     input bit disturb, input string nm);
    logic [335:0] em;
    logic eo;
    int m, lat, bh;
    model(tm, vm, em, eo);
    @(negedge CLK);
    mtrx_T_in = tm;
    mtrx_V_in = vm;
    state_in = tg;
    start = 1;
    @(negedge CLK);
    start = 0;
    m = 0;
    lat = -1;
    bh = 0;
    while (m < 200 && lat < 0) begin
      if (busy) bh++;
      if (done) lat = m;
      if (disturb && m == 5) begin
        mtrx_T_in = rmat(1);
        mtrx_V_in = rmat(1);
        state_in = ~tg;
      end
      start = disturb && (m == 10 || m == 40);
      if (lat < 0) begin
        @(negedge CLK);
        m++;
      end
    end
    start = 0;
    check({nm, "_lat"}, 336'(lat), 336'(65));
    check({nm, "_busy_cycles"}, 336'(bh), 336'(64));
    check({nm, "_busy_at_done"}, 336'(busy), 336'(0));
    check({nm, "_m"}, mtrxOut, em);
    check({nm, "_ovf"}, 336'(ovf), 336'(eo));
    check({nm, "_tag"}, 336'(matrixState), 336'(tg));
    @(negedge CLK);
    check({nm, "_done_pulse"}, 336'(done), 336'(0));
    check({nm, "_hold"}, mtrxOut, em);
  endtask

  initial begin
    logic [335:0] vm;
    rst = 0;
    start = 0;
    mtrx_T_in = '0;
    mtrx_V_in = '0;
    state_in = '0;
    repeat (3) @(negedge CLK);
    check("rst_outs", {busy, done, ovf, matrixState, mtrxOut[20:0]}, '0);
    check("rst_m", mtrxOut, '0);
    rst = 1;
    vm = rmat(0);
    run(diag(21'h000400), vm, 4'h3, 0, "ident");
    check("ident_exact", mtrxOut, vm);
    check("ident_ovf0", 336'(ovf), 336'(0));
    run(diag(21'h000800), put(rmat(0), 1, 2, 21'h1FFC00), 4'hA, 0, "dbl");
    check("dbl_neg", 336'(ge(mtrxOut, 1, 2)), 336'(21'h1FF800));
    check("dbl_tag", 336'(matrixState), 336'(4'hA));
    run(diag(21'h000800), put(rmat(0), 2, 1, 21'h0FA000), 4'h5, 0, "sat");
    check("sat_elem", 336'(ge(mtrxOut, 2, 1)), 336'(21'h0FFFFF));
    check("sat_ovf1", 336'(ovf), 336'(1));
    run(diag(21'h000400), rmat(0), 4'h6, 0, "nosat");
    check("nosat_ovf0", 336'(ovf), 336'(0));
    run(diag(21'h000200), put(put(rmat(0), 0, 0, 21'h000001), 3, 3, 21'h1FFFFF), 4'h7, 0, "half");
`ifdef VTX_ROUND_EN
    check("half_pos", 336'(ge(mtrxOut, 0, 0)), 336'(21'h000001));
    check("half_neg", 336'(ge(mtrxOut, 3, 3)), 336'(21'h000000));
`else
    check("half_pos", 336'(ge(mtrxOut, 0, 0)), 336'(21'h000000));
    check("half_neg", 336'(ge(mtrxOut, 3, 3)), 336'(21'h1FFFFF));
`endif
    run(rmat(0), rmat(0), 4'h9, 1, "disturb");
    @(negedge CLK);
    mtrx_T_in = rmat(1);
    mtrx_V_in = rmat(1);
    state_in = 4'hC;
    start = 1;
    @(negedge CLK);
    start = 0;
    repeat (30) @(negedge CLK);
    rst = 0;
    #1;
    check("midrst_ctl", 336'({busy, done, ovf, matrixState}), 336'(0));
    check("midrst_m", mtrxOut, '0);
    @(negedge CLK);
    rst = 1;
    run(rmat(0), rmat(0), 4'hD, 0, "after_rst");
    for (int i = 0; i < 6; i++) run(rmat(i[0]), rmat(i[1]), 4'($urandom), 0, "rand");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
